// File: rtl/mips_multi.sv
// Multicycle MIPS-subset core with one shared valid/ready memory port.
// Optional feature: define MIPS_MULTI_BNE_EN to decode bne (op 0x05).
module mips_multi #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic              retire,
    output logic              illegal
);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, ADDIEX, JUMP, TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
`ifdef MIPS_MULTI_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif

    state_t      r_state;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
    logic [31:0] r_regs [32];

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_dst;
    logic [31:0] w_simm, w_alu;
    logic        w_funct_ok, w_taken, w_unused_shamt;
    logic signed [31:0] w_a_s, w_b_s;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];
    assign w_simm  = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_dst   = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_a_s   = r_a;
    assign w_b_s   = r_b;
    assign w_unused_shamt = &{1'b0, r_ir[10:6]};

    always_comb begin
        w_alu      = 32'h0;
        w_funct_ok = 1'b1;
        case (w_funct)
            6'h20:   w_alu = r_a + r_b;
            6'h22:   w_alu = r_a - r_b;
            6'h24:   w_alu = r_a & r_b;
            6'h25:   w_alu = r_a | r_b;
            6'h2A:   w_alu = (w_a_s < w_b_s) ? 32'd1 : 32'd0;
            default: w_funct_ok = 1'b0;
        endcase
    end

`ifdef MIPS_MULTI_BNE_EN
    assign w_taken = (w_op == OP_BNE) ? (r_a != r_b) : (r_a == r_b);
`else
    assign w_taken = (r_a == r_b);
`endif

    // Sequencer: one state per cycle; memory states hold until mem_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_ir     <= 32'h0;
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_aluout <= 32'h0;
            r_mdr    <= 32'h0;
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
        end else begin
            case (r_state)
                IDLE: r_state <= FETCH;
                FETCH: if (mem_ready) begin
                    r_ir    <= mem_rdata;
                    r_pc    <= r_pc + 32'd4;
                    r_state <= DECODE;
                end
                DECODE: begin
                    r_a      <= r_regs[w_rs];
                    r_b      <= r_regs[w_rt];
                    r_aluout <= r_pc + (w_simm << 2);
                    case (w_op)
                        OP_RTYPE:     r_state <= w_funct_ok ? EXEC : TRAP;
                        OP_LW, OP_SW: r_state <= MEMADR;
                        OP_BEQ:       r_state <= BRANCH;
`ifdef MIPS_MULTI_BNE_EN
                        OP_BNE:       r_state <= BRANCH;
`endif
                        OP_ADDI:      r_state <= ADDIEX;
                        OP_J:         r_state <= JUMP;
                        default:      r_state <= TRAP;
                    endcase
                end
                MEMADR: begin
                    r_aluout <= r_a + w_simm;
                    r_state  <= (w_op == OP_LW) ? MEMRD : MEMWR;
                end
                MEMRD: if (mem_ready) begin
                    r_mdr   <= mem_rdata;
                    r_state <= MEMWB;
                end
                MEMWB: begin
                    if (w_rt != 5'd0) r_regs[w_rt] <= r_mdr;
                    r_state <= FETCH;
                end
                MEMWR: if (mem_ready) r_state <= FETCH;
                EXEC: begin
                    r_aluout <= w_alu;
                    r_state  <= ALUWB;
                end
                ADDIEX: begin
                    r_aluout <= r_a + w_simm;
                    r_state  <= ALUWB;
                end
                ALUWB: begin
                    if (w_dst != 5'd0) r_regs[w_dst] <= r_aluout;
                    r_state <= FETCH;
                end
                BRANCH: begin
                    if (w_taken) r_pc <= r_aluout;
                    r_state <= FETCH;
                end
                JUMP: begin
                    r_pc    <= {r_pc[31:28], r_ir[25:0], 2'b00};
                    r_state <= FETCH;
                end
                TRAP:    r_state <= TRAP;
                default: r_state <= IDLE;
            endcase
        end
    end

    logic [31:0] w_addr_full;
    assign w_addr_full = (r_state == MEMRD || r_state == MEMWR) ? r_aluout : r_pc;

    assign mem_req   = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
    assign mem_we    = (r_state == MEMWR);
    assign mem_addr  = w_addr_full[ADDR_W-1:0];
    assign mem_wdata = (r_state == MEMWR) ? r_b : 32'h0;
    assign pc        = r_pc;
    assign illegal   = (r_state == TRAP);
    // A store retires on the edge its handshake completes; other retires are pure state.
    assign retire    = (r_state == MEMWB) || (r_state == ALUWB) || (r_state == BRANCH) ||
                       (r_state == JUMP)  || ((r_state == MEMWR) && mem_ready);

endmodule

// File: tb/tb_mips_multi.sv
// Directed bench for mips_multi with a unified word memory and optional wait states.
module tb_mips_multi;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_req, mem_we, retire, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic        mem_ready = 1'b1;

    always #5 clk = ~clk;

    mips_multi dut (
        .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .retire(retire), .illegal(illegal)
    );

    logic [31:0] mem [0:1023];
    logic [31:0] img [0:1023];
    logic        do_load = 1'b0;
    int          wr_count = 0;
    logic [31:0] first_waddr = 32'h0, first_wdata = 32'h0;

    int checks = 0;
    int failures = 0;
    int wait_mode = 0;
    int wcnt = 0;
    int stab_err = 0;
    logic        stall_prev = 1'b0, s_we = 1'b0;
    logic [31:0] s_addr = 32'h0, s_wdata = 32'h0;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (do_load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= img[i];
            wr_count <= 0;
        end else if (reset_n && mem_req && mem_we && mem_ready) begin
            mem[mem_addr[11:2]] <= mem_wdata;
            if (wr_count == 0) begin
                first_waddr <= mem_addr;
                first_wdata <= mem_wdata;
            end
            wr_count <= wr_count + 1;
        end
    end

    // Ready generation plus stall-stability monitor, both on the falling edge.
    always @(negedge clk) begin
        if (stall_prev && reset_n &&
            (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata))
            stab_err++;
        if (wait_mode == 0) mem_ready = 1'b1;
        else if (wait_mode == 2) mem_ready = 1'b0;
        else if (mem_ready) begin
            mem_ready = 1'b0;
            wcnt = $urandom_range(0, 3);
        end else if (mem_req) begin
            if (wcnt == 0) mem_ready = 1'b1;
            else wcnt--;
        end
        stall_prev = reset_n && mem_req && !mem_ready;
        s_addr  = mem_addr;
        s_we    = mem_we;
        s_wdata = mem_wdata;
    end

    task automatic clear_img();
        for (int i = 0; i < 1024; i++) img[i] = 32'h0;
    endtask

    task automatic load_prog_a();
        clear_img();
        img[0]  = 32'h20020005; // addi $2,$0,5
        img[1]  = 32'h2003000C; // addi $3,$0,12
        img[2]  = 32'h00432020; // add  $4,$2,$3
        img[3]  = 32'hAC040054; // sw   $4,84($0)
        img[4]  = 32'h8C050054; // lw   $5,84($0)
        img[5]  = 32'h00433022; // sub  $6,$2,$3
        img[6]  = 32'h00C2382A; // slt  $7,$6,$2
        img[7]  = 32'h00434024; // and  $8,$2,$3
        img[8]  = 32'h00434825; // or   $9,$2,$3
        img[9]  = 32'hAC050058; // sw   $5,88
        img[10] = 32'hAC06005C; // sw   $6,92
        img[11] = 32'hAC070060; // sw   $7,96
        img[12] = 32'hAC080064; // sw   $8,100
        img[13] = 32'hAC090068; // sw   $9,104
        img[14] = 32'h20000007; // addi $0,$0,7
        img[15] = 32'hAC00006C; // sw   $0,108
        img[16] = 32'h0046502A; // slt  $10,$2,$6
        img[17] = 32'hAC0A0070; // sw   $10,112
        img[18] = 32'h08000012; // j    0x48
        for (int i = 21; i <= 28; i++) img[i] = 32'hDEADBEEF;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        do_load = 1'b1;
        @(posedge clk);
        @(posedge clk);
        do_load = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic check_mem_a(input string tag);
        logic [31:0] exp [21:28];
        exp[21] = 32'h11; exp[22] = 32'd17; exp[23] = 32'hFFFFFFF9; exp[24] = 32'd1;
        exp[25] = 32'd4;  exp[26] = 32'd13; exp[27] = 32'd0;        exp[28] = 32'd0;
        for (int i = 21; i <= 28; i++) begin
            checks++;
            if (mem[i] !== exp[i]) begin
                failures++;
                $display("FAIL %s mem[%0d] got=%h exp=%h", tag, i * 4, mem[i], exp[i]);
            end
        end
        checks++;
        if (wr_count !== 8) begin
            failures++;
            $display("FAIL %s store_count got=%0d exp=8", tag, wr_count);
        end
    endtask

    task automatic test_reset();
        load_prog_a();
        wait_mode = 0;
        reset_n = 1'b0;
        do_load = 1'b1;
        @(posedge clk);
        @(posedge clk);
        do_load = 1'b0;
        #2;
        checks++;
        if ({mem_req, mem_we, retire, illegal} !== 4'b0 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0 || pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold req/we/ret/ill=%b addr=%h wdata=%h pc=%h exp 0",
                     {mem_req, mem_we, retire, illegal}, mem_addr, mem_wdata, pc);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || retire !== 1'b0 || pc !== 32'h0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_cycle1 req=%b ret=%b pc=%h addr=%h exp 0", mem_req, retire, pc, mem_addr);
        end
    endtask

    task automatic test_program_timing();
        bit exp_ret;
        load_prog_a();
        wait_mode = 0;
        do_reset();
        for (int n = 2; n <= 22; n++) begin
            @(negedge clk);
            #1;
            if (n == 2) begin
                checks++;
                if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
                    failures++;
                    $display("FAIL first_fetch req=%b we=%b addr=%h exp 1 0 0", mem_req, mem_we, mem_addr);
                end
            end
            exp_ret = (n == 5 || n == 9 || n == 13 || n == 17 || n == 22);
            checks++;
            if (retire !== exp_ret) begin
                failures++;
                $display("FAIL retire_cycle%0d got=%b exp=%b", n, retire, exp_ret);
            end
        end
        repeat (150) @(negedge clk);
        checks++;
        if (first_waddr !== 32'd84 || first_wdata !== 32'h11) begin
            failures++;
            $display("FAIL first_store addr=%h data=%h exp 54 11", first_waddr, first_wdata);
        end
        check_mem_a("zero_wait");
    endtask

    task automatic test_wait_states();
        load_prog_a();
        stab_err = 0;
        do_reset();
        wait_mode = 1;
        repeat (900) @(negedge clk);
        wait_mode = 0;
        #1;
        check_mem_a("wait_states");
        checks++;
        if (stab_err !== 0) begin
            failures++;
            $display("FAIL stall_stability changes=%0d exp=0", stab_err);
        end
    endtask

    task automatic test_branch_jump();
        logic [31:0] seq [$];
        logic [31:0] exp [9];
        clear_img();
        img[0] = 32'h20020005; // addi $2,$0,5
        img[1] = 32'h20000000;
        img[2] = 32'h20000000;
        img[3] = 32'h20000000;
        img[4] = 32'h10420002; // beq $2,$2,+2
        img[5] = 32'hFC000000;
        img[6] = 32'hFC000000;
        img[7] = 32'h10400005; // beq $2,$0,+5 (not taken)
        img[8] = 32'h08000040; // j 0x100
        img[64] = 32'h08000040;
        exp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h1C, 32'h20, 32'h100, 32'h100};
        wait_mode = 0;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            #1;
            if (mem_req && !mem_we && mem_ready) seq.push_back(mem_addr);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (i >= seq.size()) begin
                failures++;
                $display("FAIL fetch_seq[%0d] missing exp=%h", i, exp[i]);
            end else if (seq[i] !== exp[i]) begin
                failures++;
                $display("FAIL fetch_seq[%0d] got=%h exp=%h", i, seq[i], exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        int bad;
        clear_img();
        img[0] = 32'hFC000000;
        wait_mode = 0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (illegal !== 1'b0) begin
            failures++;
            $display("FAIL illegal_decode got=%b exp=0", illegal);
        end
        @(negedge clk);
        #1;
        checks++;
        if (illegal !== 1'b1) begin
            failures++;
            $display("FAIL illegal_rise got=%b exp=1", illegal);
        end
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            #1;
            if (mem_req !== 1'b0 || retire !== 1'b0 || illegal !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL trap_quiet bad_cycles=%0d exp=0", bad);
        end
        clear_img(); // word 0 = sll, an unsupported funct
        do_reset();
        checks++;
        if (illegal !== 1'b0 || pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_clears_trap illegal=%b pc=%h exp 0 0", illegal, pc);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL restart_fetch req=%b addr=%h exp 1 0", mem_req, mem_addr);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (illegal !== 1'b1) begin
            failures++;
            $display("FAIL bad_funct_trap got=%b exp=1", illegal);
        end
    endtask

    task automatic test_reset_mid_transfer();
        clear_img();
        img[0] = 32'h20020005;
        wait_mode = 2;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold req=%b exp=1", mem_req);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || pc !== 32'h0) begin
            failures++;
            $display("FAIL async_abort req=%b pc=%h exp 0 0", mem_req, pc);
        end
        wait_mode = 0;
        @(negedge clk);
    endtask

    task automatic test_bne();
        clear_img();
        img[0] = 32'h20020005; // addi $2,$0,5
        img[1] = 32'h14430001; // bne $2,$3,+1
        img[2] = 32'hFC000000;
        img[3] = 32'h08000003; // j 0xC
        wait_mode = 0;
        do_reset();
        repeat (14) @(negedge clk);
        #1;
`ifdef MIPS_MULTI_BNE_EN
        checks++;
        if (illegal !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'hC) begin
            failures++;
            $display("FAIL bne_taken ill=%b req=%b addr=%h exp 0 1 c", illegal, mem_req, mem_addr);
        end
`else
        checks++;
        if (illegal !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL bne_trap ill=%b req=%b exp 1 0", illegal, mem_req);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_program_timing();
        test_wait_states();
        test_branch_jump();
        test_illegal();
        test_reset_mid_transfer();
        test_bne();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
